// File: rtl/lsu_pkg.sv
// Shared encodings for the sub-word load/store unit: access sizes, FSM state
// type and the alignment rule used by both the FSM and the lane logic.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RMW_RD,
    WR,
    RESP
  } lsu_state_e;

  // Size 2'b11 is handled as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: little-endian extract/extend for loads and
// read-modify-write merge of the store lane(s) into the fetched word.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] mem_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  function automatic logic [31:0] ext8(input logic signed [7:0] v, input logic zext);
    logic signed [31:0] s;
    s = {{24{v[7]}}, v};
    return zext ? {24'h000000, v} : s;
  endfunction

  function automatic logic [31:0] ext16(input logic signed [15:0] v, input logic zext);
    logic signed [31:0] s;
    s = {{16{v[15]}}, v};
    return zext ? {16'h0000, v} : s;
  endfunction

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = mem_word[{addr_lo, 3'b000} +: 8];
    half_lane = mem_word[{addr_lo[1], 4'b0000} +: 16];
    load_data = mem_word;
    merged    = wdata;
    case (size)
      SZ_BYTE: begin
        load_data = ext8(byte_lane, is_unsigned);
        merged    = mem_word;
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = ext16(half_lane, is_unsigned);
        merged    = mem_word;
        merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_subword.sv
// Sub-word load/store unit: byte/half/word accesses over a word-wide memory
// port, with RMW for sub-word stores. LSU_SUBWORD_TIMEOUT_EN adds an ack watchdog.
module lsu_subword
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        misalign_o,
  output logic        timeout_o,
  output logic        mem_rd_en_o,
  output logic        mem_wr_en_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i
);

  lsu_state_e  state, state_nxt;
  logic [31:0] addr_q, wbuf_q, rdata_q;
  logic [1:0]  size_q;
  logic        uns_q, misalign_q;
  logic [31:0] load_data, merged;
  logic        mem_st, tmo_hit, req_mis;

  assign mem_st  = (state == RD) || (state == RMW_RD) || (state == WR);
  assign req_mis = is_misaligned(size_i, addr_i[1:0]);

  lsu_lane u_lane (
    .size        (size_q),
    .is_unsigned (uns_q),
    .addr_lo     (addr_q[1:0]),
    .mem_word    (mem_data_i),
    .wdata       (wbuf_q),
    .load_data   (load_data),
    .merged      (merged)
  );

`ifdef LSU_SUBWORD_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             timeout_q;

  // Counts cycles spent in the current memory state; any state change restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state_nxt != state) begin
      tmo_cnt <= '0;
    end else if (mem_st) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else if (state == IDLE && req_i) begin
      timeout_q <= 1'b0;
    end else if (tmo_hit) begin
      timeout_q <= 1'b1;
    end
  end

  assign tmo_hit   = mem_st && !mem_ack_i && (tmo_cnt == CNT_LAST);
  assign timeout_o = (state == RESP) && timeout_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
  assign tmo_hit        = 1'b0;
  assign timeout_o      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_i) begin
          if (req_mis)        state_nxt = RESP;
          else if (!we_i)     state_nxt = RD;
          else if (size_i[1]) state_nxt = WR;
          else                state_nxt = RMW_RD;
        end
      end
      RD:      if (mem_ack_i || tmo_hit) state_nxt = RESP;
      RMW_RD: begin
        if (mem_ack_i)    state_nxt = WR;
        else if (tmo_hit) state_nxt = RESP;
      end
      WR:      if (mem_ack_i || tmo_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, load result and the merged store word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      wbuf_q     <= '0;
      misalign_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            addr_q     <= addr_i;
            size_q     <= size_i;
            uns_q      <= unsigned_i;
            wbuf_q     <= wdata_i;
            misalign_q <= req_mis;
            if (!we_i && req_mis) rdata_q <= '0;
          end
        end
        RD: begin
          if (mem_ack_i)    rdata_q <= load_data;
          else if (tmo_hit) rdata_q <= '0;
        end
        RMW_RD:  if (mem_ack_i) wbuf_q <= merged;
        default: ;
      endcase
    end
  end

  assign rdata_o     = rdata_q;
  assign done_o      = (state == RESP);
  assign busy_o      = (state != IDLE);
  assign misalign_o  = (state == RESP) && misalign_q;
  assign mem_rd_en_o = (state == RD) || (state == RMW_RD);
  assign mem_wr_en_o = (state == WR);
  assign mem_addr_o  = mem_st ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_data_o  = (state == WR) ? wbuf_q : 32'h0;

endmodule

// File: tb/tb_lsu_subword.sv
// Randomised self-checking bench for lsu_subword against a word-array memory
// model; also covers reset, hold-request and (with LSU_SUBWORD_TIMEOUT_EN) timeout.
module tb_lsu_subword;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0, we_i = 1'b0, unsigned_i = 1'b0, mem_ack_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic [31:0] addr_i = 32'h0, wdata_i = 32'h0;
  logic [31:0] mem_data_i;
  logic [31:0] rdata_o, mem_addr_o, mem_data_o;
  logic        done_o, busy_o, misalign_o, timeout_o, mem_rd_en_o, mem_wr_en_o;

  lsu_subword #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .we_i        (we_i),
    .size_i      (size_i),
    .unsigned_i  (unsigned_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .done_o      (done_o),
    .busy_o      (busy_o),
    .misalign_o  (misalign_o),
    .timeout_o   (timeout_o),
    .mem_rd_en_o (mem_rd_en_o),
    .mem_wr_en_o (mem_wr_en_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .mem_ack_i   (mem_ack_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Memory seen by the DUT (16 words at 0x100) and the model's copy.
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  logic        poke_en = 1'b0;
  logic [3:0]  poke_idx = 4'h0;
  logic [31:0] poke_val = 32'h0;

  assign mem_data_i = mem[mem_addr_o[5:2]];

  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_val;
    else if (mem_wr_en_o && mem_ack_i) mem[mem_addr_o[5:2]] <= mem_data_o;
  end

  // 0: ack always, 1: random ack with at most two stall cycles, 2: never ack.
  int ack_mode = 0;
  int stall = 0;
  always @(negedge clk) begin
    if (ack_mode == 0) mem_ack_i = 1'b1;
    else if (ack_mode == 2) mem_ack_i = 1'b0;
    else if (stall >= 2) begin
      mem_ack_i = 1'b1;
      stall = 0;
    end else begin
      mem_ack_i = 1'($urandom_range(0, 1));
      if (mem_ack_i) stall = 0;
      else if (mem_rd_en_o || mem_wr_en_o) stall++;
    end
  end

  // Model state for the access in flight.
  logic        m_exp_rd = 1'b0, m_exp_wr = 1'b0;
  logic [31:0] m_addr = 32'h0, m_store_word = 32'h0, m_rdata = 32'h0;
  int          rd_cnt = 0;

  function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b00) return 1'b0;
    if (sz == 2'b01) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic uns, input logic [31:0] a);
    logic [31:0] v;
    int          sh;
    sh = 8 * int'(a[1:0]);
    if (sz == 2'b00) begin
      v = (w >> sh) & 32'hFF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
    end else if (sz == 2'b01) begin
      v = (w >> sh) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] mask;
    int          sh;
    sh = 8 * int'(a[1:0]);
    if (sz == 2'b00) begin
      mask = 32'hFF << sh;
      return (old & ~mask) | ((wd & 32'hFF) << sh);
    end
    if (sz == 2'b01) begin
      mask = 32'hFFFF << sh;
      return (old & ~mask) | ((wd & 32'hFFFF) << sh);
    end
    return wd;
  endfunction

  // Per-cycle compare process: flag qualification and strobe legality.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd_en_o) rd_cnt++;
      if (!done_o) chk("flags_without_done", {30'h0, misalign_o, timeout_o}, 32'h0);
      if (mem_rd_en_o || mem_wr_en_o)
        chk("mem_addr", mem_addr_o, {m_addr[31:2], 2'b00});
      if (mem_rd_en_o) chk("rd_strobe_allowed", 32'(m_exp_rd), 32'h1);
      if (mem_wr_en_o) begin
        chk("wr_strobe_allowed", 32'(m_exp_wr), 32'h1);
        chk("wr_data", mem_data_o, m_store_word);
      end
    end
  end

  task automatic poke(input int idx, input logic [31:0] v);
    @(negedge clk);
    poke_en  = 1'b1;
    poke_idx = idx[3:0];
    poke_val = v;
    @(posedge clk);
    #1 poke_en = 1'b0;
    ref_mem[idx] = v;
  endtask

  task automatic set_ack(input int mode);
    ack_mode = mode;
    repeat (2) @(negedge clk);
  endtask

  task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic hold, input logic tmo);
    logic [31:0] old, nw, exp_rd;
    logic        mis;
    int          idx, lat, exp_lat;
    idx    = int'(a[5:2]);
    old    = ref_mem[idx];
    mis    = model_mis(sz, a);
    nw     = (we && !mis && !tmo) ? model_store(old, wd, sz, a) : old;
    exp_rd = we ? m_rdata : ((mis || tmo) ? 32'h0 : model_load(old, sz, uns, a));
    if (mis)           exp_lat = 1;
    else if (tmo)      exp_lat = 1 + TMO;
    else if (!we || sz[1]) exp_lat = 2;
    else               exp_lat = 3;
    @(negedge clk);
    m_addr       = a;
    m_store_word = model_store(old, wd, sz, a);
    m_exp_rd     = !mis && (!we || !sz[1]);
    m_exp_wr     = !mis && we && !tmo;
    req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns; addr_i = a; wdata_i = wd;
    @(posedge clk);
    #1 lat = 1;
    if (!hold) req_i = 1'b0;
    while (!done_o && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("done_seen", 32'(done_o), 32'h1);
    if (ack_mode != 1 || mis) chk("latency", lat, exp_lat);
    chk("misalign", 32'(misalign_o), 32'(mis));
    chk("timeout", 32'(timeout_o), 32'(tmo));
    chk("rdata", rdata_o, exp_rd);
    ref_mem[idx] = nw;
    m_rdata      = exp_rd;
    chk("mem_word", mem[idx], nw);
    @(posedge clk);
    #1 chk("done_one_cycle", 32'(done_o), 32'h0);
    chk("idle_after_done", 32'(busy_o), 32'h0);
    chk("rdata_hold", rdata_o, exp_rd);
    if (hold) begin
      @(posedge clk);
      #1 chk("restart_from_idle", 32'(busy_o), 32'h1);
      req_i = 1'b0;
      lat = 0;
      while (!done_o && lat < 40) begin
        @(posedge clk);
        #1 lat++;
      end
      chk("second_done", 32'(done_o), 32'h1);
      chk("second_rdata", rdata_o, exp_rd);
      @(posedge clk);
      #1;
    end
    m_exp_rd = 1'b0;
    m_exp_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit actual=%0t required=<200000", $time);
    $fatal(1, "time limit");
  end

  initial begin
    int cnt0;
    logic [1:0] sz;
    // Reset state, with a request pending to show reset dominates.
    req_i = 1'b1;
    for (int i = 0; i < 16; i++) poke(i, $urandom);
    poke(0, 32'h88223344);
    @(negedge clk);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_ctrl", {26'h0, done_o, busy_o, misalign_o, timeout_o, mem_rd_en_o, mem_wr_en_o}, 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_data", mem_data_o, 32'h0);
    req_i = 1'b0;
    rst_n = 1'b1;
    set_ack(0);

    // Loads from 0x88223344.
    access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1'b0, 1'b0);
    chk("lb_literal", rdata_o, 32'hFFFFFF88);
    access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1'b0, 1'b0);
    chk("lbu_literal", rdata_o, 32'h00000088);
    access(1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0);
    chk("lh_literal", rdata_o, 32'h00003344);

    // Sub-word stores into 0x11223344.
    poke(0, 32'h11223344);
    access(1'b1, 2'b00, 1'b0, 32'h102, 32'h000000AB, 1'b0, 1'b0);
    chk("sb_literal", mem[0], 32'h11AB3344);
    poke(0, 32'h11223344);
    access(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000BEEF, 1'b0, 1'b0);
    chk("sh_literal", mem[0], 32'hBEEF3344);

    // Misaligned word store: no strobes, done after one cycle.
    cnt0 = rd_cnt;
    access(1'b1, 2'b10, 1'b0, 32'h102, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("misalign_no_read", rd_cnt - cnt0, 0);

    // Request held high through a word load.
    cnt0 = rd_cnt;
    access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0);
    chk("hold_reads", rd_cnt - cnt0, 2);

    // Reset pulse while waiting in RMW_RD.
    set_ack(2);
    @(negedge clk);
    m_addr = 32'h101; m_exp_rd = 1'b1; m_exp_wr = 1'b0;
    req_i = 1'b1; we_i = 1'b1; size_i = 2'b00; addr_i = 32'h101; wdata_i = 32'h5A;
    @(posedge clk);
    #1 req_i = 1'b0;
    @(posedge clk);
    #1 chk("rmw_rd_strobe", 32'(mem_rd_en_o), 32'h1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_strobes", {30'h0, mem_rd_en_o, mem_wr_en_o}, 32'h0);
    chk("rst_mid_busy", 32'(busy_o), 32'h0);
    chk("rst_mid_addr", mem_addr_o, 32'h0);
    m_exp_rd = 1'b0;
    m_rdata  = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_mem", mem[0], ref_mem[0]);
    chk("rst_mid_rdata", rdata_o, 32'h0);
    set_ack(0);

`ifdef LSU_SUBWORD_TIMEOUT_EN
    poke(1, 32'hCAFEF00D);
    access(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 1'b0, 1'b0);
    set_ack(2);
    access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1);
    chk("tmo_rdata_literal", rdata_o, 32'h0);
    access(1'b1, 2'b00, 1'b0, 32'h105, 32'h77, 1'b0, 1'b1);
    set_ack(0);
`endif

    // Randomised mix of sizes, signedness, alignment and ack behaviour.
    for (int i = 0; i < 150; i++) begin
      if (i % 25 == 0) set_ack(int'($urandom_range(0, 1)));
      sz = 2'($urandom_range(0, 3));
      access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             32'h100 + 32'($urandom_range(0, 63)), $urandom, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
